// File: rtl/demux1to4_framer.sv
// -----------------------------------------------------------------------------
// demux1to4_framer
//
// Time-division 1-to-4 demultiplexer. A serial stream of WIDTH-bit beats is
// steered into four registered output lanes.
//   * Auto mode (sel_mode = 0): beats fill lanes 0,1,2,3 in rotation. The first
//     three beats are held in shadow registers, and the whole frame is committed
//     to dout on the 4th beat, so consumers never see a half-updated frame.
//   * Explicit mode (sel_mode = 1): each beat is written straight into lane sel.
//
// Ports
//   clock        in   rising-edge system clock
//   resetn       in   asynchronous active-low reset
//   din          in   WIDTH   beat data
//   din_valid    in   1       beat present this cycle
//   frame_sync   in   1       with din_valid, forces this beat to lane 0
//   sel_mode     in   1       0 = auto rotate, 1 = explicit select
//   sel          in   2       target lane in explicit mode
//   dout         out  4*WIDTH lane k at bits [k*WIDTH +: WIDTH]
//   lane_strobe  out  4       one-hot/all-ones pulse marking lanes just written
//   frame_valid  out  1       one-cycle pulse after an auto-mode frame commit
//   cur_ch       out  2       lane the next auto-mode beat will target
//   frame_count  out  CNT_W   committed auto-mode frames, wrapping
// -----------------------------------------------------------------------------
module demux1to4_framer #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               frame_sync,
    input  logic               sel_mode,
    input  logic [1:0]         sel,
    output logic [4*WIDTH-1:0] dout,
    output logic [3:0]         lane_strobe,
    output logic               frame_valid,
    output logic [1:0]         cur_ch,
    output logic [CNT_W-1:0]   frame_count
);

    // Auto-mode fill pointer. LANE0 is the EMPTY state, LANE1..LANE3 are FILLING.
    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } ptr_t;

    ptr_t             ch_ptr;
    ptr_t             ch_next;
    logic [1:0]       p_eff;
    logic             mode_q;
    logic [WIDTH-1:0] shadow [3];
    logic             commit;
    logic             shadow_we;
    logic             explicit_we;

    // Next pointer and write controls.
    always_comb begin
        ch_next     = ch_ptr;
        p_eff       = ch_ptr;
        commit      = 1'b0;
        shadow_we   = 1'b0;
        explicit_we = 1'b0;

        // A mode change abandons any partial frame; the beat of this same
        // cycle is then handled under the new mode starting from lane 0.
        if (sel_mode != mode_q) begin
            p_eff = 2'd0;
        end

        if (sel_mode) begin
            ch_next     = LANE0;
            explicit_we = din_valid;
        end else begin
            if (din_valid && frame_sync) begin
                p_eff = 2'd0;
            end
            ch_next = ptr_t'(p_eff);
            if (din_valid) begin
                if (p_eff == 2'd3) begin
                    commit  = 1'b1;
                    ch_next = LANE0;
                end else begin
                    shadow_we = 1'b1;
                    ch_next   = ptr_t'(p_eff + 2'd1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ch_ptr <= LANE0;
        end else begin
            ch_ptr <= ch_next;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mode_q      <= 1'b0;
            dout        <= '0;
            lane_strobe <= '0;
            frame_valid <= 1'b0;
            frame_count <= '0;
            for (int k = 0; k < 3; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            mode_q      <= sel_mode;
            lane_strobe <= '0;
            frame_valid <= 1'b0;

            for (int k = 0; k < 3; k++) begin
                if (shadow_we && (p_eff == 2'(k))) begin
                    shadow[k] <= din;
                end
            end

            // The 4th beat bypasses the shadows and lands in lane 3 directly,
            // so the frame is visible the cycle after its last beat.
            if (commit) begin
                dout        <= {din, shadow[2], shadow[1], shadow[0]};
                lane_strobe <= 4'b1111;
                frame_valid <= 1'b1;
                frame_count <= frame_count + CNT_W'(1);
            end

            if (explicit_we) begin
                dout[int'(sel)*WIDTH +: WIDTH] <= din;
                lane_strobe                    <= 4'b0001 << sel;
            end
        end
    end

    assign cur_ch = ch_ptr;

endmodule
